// File: rtl/sysmem_arb.sv
// sysmem_arb: shares one 1024x8 single-port RAM between a 32-bit CPU word
// port (four byte-lane cycles per word) and an 8-bit loader byte port.
// Ports: clka/rsta clock and async reset; cpu_* word request/response;
// ld_* byte request/response; ram_* drive and read the RAM port.
module sysmem_arb #(
    parameter int ADDR_W    = 10,
    parameter int CPU_FIRST = 1
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              cpu_valid,
    input  logic [ADDR_W-3:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    input  logic              ld_valid,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_wdata,
    output logic              ld_ready,
    output logic [7:0]        ld_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dia,
    output logic              ram_cea,
    output logic              ram_wea,
    input  logic [7:0]        ram_doa
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_ACC,
        CPU_END,
        LD_ACC,
        LD_END
    } state_t;

    // Last-granted flag starts pointing at the port that must lose the
    // first contention.
    localparam logic LAST_CPU_RST = (CPU_FIRST == 0);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        last_cpu_q, last_cpu_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic        ld_ready_q, ld_ready_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [7:0]  ld_rdata_q, ld_rdata_d;
    logic [1:0]  lane;
    logic        cea_c, wea_c;
    logic [ADDR_W-1:0] addr_c;
    logic [7:0]  dia_c;

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            last_cpu_q  <= LAST_CPU_RST;
            cpu_ready_q <= 1'b0;
            ld_ready_q  <= 1'b0;
            cpu_rdata_q <= 32'd0;
            ld_rdata_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_cpu_q  <= last_cpu_d;
            cpu_ready_q <= cpu_ready_d;
            ld_ready_q  <= ld_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_cpu_d  = last_cpu_q;
        cpu_ready_d = 1'b0;
        ld_ready_d  = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ld_rdata_d  = ld_rdata_q;
        lane        = cnt_q - 2'd1;
        cea_c       = 1'b0;
        wea_c       = 1'b0;
        addr_c      = '0;
        dia_c       = 8'd0;
        case (state_q)
            IDLE: begin
                if (cpu_valid && (!ld_valid || !last_cpu_q)) begin
                    state_d    = CPU_ACC;
                    cnt_d      = 2'd0;
                    last_cpu_d = 1'b1;
                end else if (ld_valid) begin
                    state_d    = LD_ACC;
                    last_cpu_d = 1'b0;
                end
            end
            CPU_ACC: begin
                cea_c  = 1'b1;
                addr_c = {cpu_addr, cnt_q};
                dia_c  = cpu_wdata[{cnt_q, 3'b000} +: 8];
                wea_c  = cpu_wstrb[cnt_q];
                // RAM data lags the address by one cycle.
                if (cnt_q != 2'd0)
                    cpu_rdata_d[{lane, 3'b000} +: 8] = ram_doa;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d     = CPU_END;
                    cpu_ready_d = 1'b1;
                end
            end
            CPU_END: begin
                cpu_rdata_d[31:24] = ram_doa;
                state_d            = IDLE;
            end
            LD_ACC: begin
                cea_c      = 1'b1;
                addr_c     = ld_addr;
                dia_c      = ld_wdata;
                wea_c      = ld_we;
                state_d    = LD_END;
                ld_ready_d = 1'b1;
            end
            LD_END: begin
                ld_rdata_d = ram_doa;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The final byte only arrives in the ready cycle, so it is forwarded
    // from the RAM output then; the flop holds the full word afterwards.
    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = cpu_ready_q ? {ram_doa, cpu_rdata_q[23:0]}
                                   : cpu_rdata_q;
    assign ld_ready  = ld_ready_q;
    assign ld_rdata  = ld_ready_q ? ram_doa : ld_rdata_q;

    assign ram_cea  = cea_c & ~rsta;
    assign ram_wea  = wea_c & ~rsta;
    assign ram_addr = addr_c;
    assign ram_dia  = dia_c;

endmodule

// File: doc/sysmem_arb.md
SYSMEM_ARB -- requirements
Module: sysmem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, the byte address width of the shared RAM (1024 x 8).
REQ-002 SHALL have parameter CPU_FIRST, default 1; 1 means the CPU port wins the first contention after reset, 0 means the loader port wins it.
REQ-003 clka  input  1  single clock; all state updates on rising edge.
REQ-004 rsta  input  1  asynchronous, active-high reset.
REQ-005 cpu_valid  input  1  CPU word request; held with its fields until cpu_ready.
REQ-006 cpu_addr  input  ADDR_W-2  CPU word address.
REQ-007 cpu_wdata  input  32  CPU write data, little-endian.
REQ-008 cpu_wstrb  input  4  byte-lane write enables; 0000 means a read.
REQ-009 cpu_ready  output  1  one-cycle completion pulse, registered.
REQ-010 cpu_rdata  output  32  read word, registered, valid while cpu_ready=1.
REQ-011 ld_valid / ld_we  input  1 / 1  loader byte request and write flag, held until ld_ready.
REQ-012 ld_addr / ld_wdata  input  ADDR_W / 8  loader byte address and write data.
REQ-013 ld_ready / ld_rdata  output  1 / 8  one-cycle completion pulse and read byte, both registered.
REQ-014 ram_addr / ram_dia  output  ADDR_W / 8  to RAM addra/dia.
REQ-015 ram_cea / ram_wea  output  1 / 1  to RAM cea/wea.
REQ-016 ram_doa  input  8  from RAM doa, unregistered read with data valid the cycle after the address cycle.

Function
REQ-017 SHALL implement states IDLE, CPU_ACC (2-bit lane counter cnt 0..3), CPU_END, LD_ACC and LD_END.
REQ-018 SHALL arbitrate in IDLE only: a single requester is granted; on simultaneous requests the port not granted last wins; the last-granted flag resets to the value that makes CPU_FIRST hold.
REQ-019 SHALL transition IDLE->CPU_ACC with cnt=0 on a CPU grant, and IDLE->LD_ACC on a loader grant.
REQ-020 SHALL drive the following in CPU_ACC: ram_cea=1, ram_addr={cpu_addr,cnt}, ram_dia=cpu_wdata[8*cnt+7:8*cnt], ram_wea=cpu_wstrb[cnt]; cnt increments each cycle; after cnt=3 the state goes to CPU_END.
REQ-021 SHALL capture ram_doa into cpu_rdata lane cnt-1 in CPU_ACC cycles with cnt>=1, and into lane 3 in CPU_END.
REQ-022 SHALL leave RAM bytes of lanes with cpu_wstrb=0 unmodified; a masked lane performs a read-only cycle.
REQ-023 SHALL in CPU_END drive ram_cea=0, set cpu_ready=1 for exactly one cycle with the full cpu_rdata, then return to IDLE.
REQ-024 SHALL give CPU latency as follows: request sampled in IDLE at cycle 0, lane cycles 1-4, cpu_ready in cycle 5.
REQ-025 SHALL in LD_ACC drive ram_cea=1, ram_addr=ld_addr, ram_dia=ld_wdata, ram_wea=ld_we for one cycle, then enter LD_END.
REQ-026 SHALL in LD_END capture ram_doa into ld_rdata, pulse ld_ready for one cycle, and return to IDLE; the request sampled at cycle 0 gives ld_ready in cycle 2.
REQ-027 SHALL drive ram_cea=0, ram_wea=0, ram_addr=0 and ram_dia=0 in IDLE, CPU_END and LD_END.
REQ-028 SHALL complete a granted transaction even if its valid drops mid-transaction (a protocol violation), with no second transaction started.
REQ-029 SHALL NOT assert cpu_ready and ld_ready in the same cycle, and SHALL never grant both ports.
REQ-030 SHALL leave the read data of a write transaction unspecified.

Reset
REQ-031 SHALL force the following immediately while rsta=1, independent of clka: state IDLE, cnt=0, cpu_ready=0, ld_ready=0, cpu_rdata=0, ld_rdata=0, last-granted flag per REQ-018.
REQ-032 SHALL drop ram_cea and ram_wea to 0 combinationally when rsta asserts mid-transaction; the aborted transaction SHALL produce no ready pulse.
REQ-033 SHALL serve a request held across reset release normally, starting from IDLE.

Verification
REQ-034 Reset: assert rsta with clka stopped -> all outputs 0 and ram_cea=0 without any clock edge.
REQ-035 CPU write of 0xDDCCBBAA to word 0x10 with wstrb 1111 -> ram_addr 0x040..0x043 with dia AA, BB, CC, DD and wea=1 in cycles 1-4, cpu_ready in cycle 5; a read of word 0x10 then returns cpu_rdata=0xDDCCBBAA.
REQ-036 CPU write of 0x00110000 to word 0x10 with wstrb 0100 -> only 0x042 written (0x11); readback returns 0xDD11BBAA.
REQ-037 Loader write of 0x5A to 0x3FF, then loader read of 0x3FF -> ld_ready in cycle 2 each time, ld_rdata=0x5A.
REQ-038 cpu_valid and ld_valid raised together after reset (CPU_FIRST=1) -> CPU served first, then loader; a repeat simultaneous request after a CPU grant -> loader served first.
REQ-039 rsta pulsed during CPU_ACC cnt=1 -> ram_cea=0 at once and no cpu_ready; after release, a held request completes in 6 cycles.
